tlb: RTL and testbench

TLB -- requirements
Module: tlb

---
 rtl/tlb_pkg.sv | 26 ++
 rtl/tlb_lookup.sv | 64 ++++++
 rtl/tlb.sv | 109 ++++++++++
 tb/tb_tlb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB constants and the entry record used by storage and lookup.
package tlb_pkg;

  localparam int TLBNUM       = 16;
  localparam int TLBNUM_WIDTH = 4;
  localparam int VPN2_W       = 19;
  localparam int ASID_W       = 8;
  localparam int PFN_W        = 20;
  localparam int C_W          = 3;

  typedef struct packed {
    logic              e;
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_lookup.sv
// One combinational search port: per-entry match, lowest-index select,
// then odd/even page half select.
module tlb_lookup #(
  parameter int TLBNUM       = tlb_pkg::TLBNUM,
  parameter int TLBNUM_WIDTH = tlb_pkg::TLBNUM_WIDTH
) (
  input  tlb_pkg::tlb_entry_t [TLBNUM-1:0] i_entries,
  input  logic [tlb_pkg::VPN2_W-1:0]       i_vpn2,
  input  logic                             i_odd_page,
  input  logic [tlb_pkg::ASID_W-1:0]       i_asid,
  output logic                             o_found,
  output logic [TLBNUM_WIDTH-1:0]          o_index,
  output logic [tlb_pkg::PFN_W-1:0]        o_pfn,
  output logic [tlb_pkg::C_W-1:0]          o_c,
  output logic                             o_d,
  output logic                             o_v
);
  import tlb_pkg::*;

  logic [TLBNUM-1:0]       w_match;
  logic [TLBNUM_WIDTH-1:0] w_hit_idx;
  logic                    w_found;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_match[i] = i_entries[i].e && (i_entries[i].vpn2 == i_vpn2) &&
                   (i_entries[i].g || (i_entries[i].asid == i_asid));
    end
  end

  // Scan high to low so the lowest matching index is the last one assigned.
  always_comb begin
    w_hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = TLBNUM_WIDTH'(i);
    end
  end

  assign w_found = |w_match;

  always_comb begin
    o_found = w_found;
    o_index = w_hit_idx;
    o_pfn   = '0;
    o_c     = '0;
    o_d     = 1'b0;
    o_v     = 1'b0;
    if (w_found) begin
      if (i_odd_page) begin
        o_pfn = i_entries[w_hit_idx].pfn1;
        o_c   = i_entries[w_hit_idx].c1;
        o_d   = i_entries[w_hit_idx].d1;
        o_v   = i_entries[w_hit_idx].v1;
      end else begin
        o_pfn = i_entries[w_hit_idx].pfn0;
        o_c   = i_entries[w_hit_idx].c0;
        o_d   = i_entries[w_hit_idx].d0;
        o_v   = i_entries[w_hit_idx].v0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// TLB top: entry storage with one write port, one combinational read port
// and two independent combinational search ports.
module tlb #(
  parameter int TLBNUM       = tlb_pkg::TLBNUM,
  parameter int TLBNUM_WIDTH = tlb_pkg::TLBNUM_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [18:0]                 s0_vpn2,
  input  logic [0:0]                  s0_odd_page,
  input  logic [7:0]                  s0_asid,
  output logic                        s0_found,
  output logic [TLBNUM_WIDTH-1:0]     s0_index,
  output logic [19:0]                 s0_pfn,
  output logic [2:0]                  s0_c,
  output logic                        s0_d,
  output logic                        s0_v,
  input  logic [18:0]                 s1_vpn2,
  input  logic [0:0]                  s1_odd_page,
  input  logic [7:0]                  s1_asid,
  output logic                        s1_found,
  output logic [TLBNUM_WIDTH-1:0]     s1_index,
  output logic [19:0]                 s1_pfn,
  output logic [2:0]                  s1_c,
  output logic                        s1_d,
  output logic                        s1_v,
  input  logic                        we,
  input  logic [TLBNUM_WIDTH-1:0]     w_index,
  input  logic [18:0]                 w_vpn2,
  input  logic [7:0]                  w_asid,
  input  logic                        w_g,
  input  logic [19:0]                 w_pfn0,
  input  logic [2:0]                  w_c0,
  input  logic                        w_d0,
  input  logic                        w_v0,
  input  logic [19:0]                 w_pfn1,
  input  logic [2:0]                  w_c1,
  input  logic                        w_d1,
  input  logic                        w_v1,
  input  logic [TLBNUM_WIDTH-1:0]     r_index,
  output logic [18:0]                 r_vpn2,
  output logic [7:0]                  r_asid,
  output logic                        r_g,
  output logic [19:0]                 r_pfn0,
  output logic [2:0]                  r_c0,
  output logic                        r_d0,
  output logic                        r_v0,
  output logic [19:0]                 r_pfn1,
  output logic [2:0]                  r_c1,
  output logic                        r_d1,
  output logic                        r_v1
);
  import tlb_pkg::*;

  tlb_entry_t [TLBNUM-1:0] r_tlb;
  tlb_entry_t              w_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tlb <= '0;
    end else if (we) begin
      r_tlb[w_index] <= '{e: 1'b1, vpn2: w_vpn2, asid: w_asid, g: w_g,
                          pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                          pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
    end
  end

  // Entries not present read back as zero regardless of stored fields.
  assign w_rd = r_tlb[r_index].e ? r_tlb[r_index] : '0;

  assign r_vpn2 = w_rd.vpn2;
  assign r_asid = w_rd.asid;
  assign r_g    = w_rd.g;
  assign r_pfn0 = w_rd.pfn0;
  assign r_c0   = w_rd.c0;
  assign r_d0   = w_rd.d0;
  assign r_v0   = w_rd.v0;
  assign r_pfn1 = w_rd.pfn1;
  assign r_c1   = w_rd.c1;
  assign r_d1   = w_rd.d1;
  assign r_v1   = w_rd.v1;

  tlb_lookup #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_lookup_s0 (
    .i_entries  (r_tlb),
    .i_vpn2     (s0_vpn2),
    .i_odd_page (s0_odd_page[0]),
    .i_asid     (s0_asid),
    .o_found    (s0_found),
    .o_index    (s0_index),
    .o_pfn      (s0_pfn),
    .o_c        (s0_c),
    .o_d        (s0_d),
    .o_v        (s0_v)
  );

  tlb_lookup #(.TLBNUM(TLBNUM), .TLBNUM_WIDTH(TLBNUM_WIDTH)) u_lookup_s1 (
    .i_entries  (r_tlb),
    .i_vpn2     (s1_vpn2),
    .i_odd_page (s1_odd_page[0]),
    .i_asid     (s1_asid),
    .o_found    (s1_found),
    .o_index    (s1_index),
    .o_pfn      (s1_pfn),
    .o_c        (s1_c),
    .o_d        (s1_d),
    .o_v        (s1_v)
  );

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: reset, write/search, global/priority,
// same-cycle write visibility and asynchronous reset.
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic [0:0]  s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s0_v, s1_d, s1_v;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tlb u_dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  function automatic logic [79:0] rd_all();
    return {2'b00, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
            r_pfn1, r_c1, r_d1, r_v1};
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2,
                    input logic [7:0] asid, input logic g,
                    input logic [19:0] pfn0, input logic [2:0] c0,
                    input logic d0, input logic v0,
                    input logic [19:0] pfn1, input logic [2:0] c1,
                    input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    s0_vpn2 = '0; s0_odd_page = '0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = '0; s1_asid = '0;
    r_index = '0;
    #1 check("rst_s0_found", 80'(s0_found), 80'd0);
    check("rst_s1_found", 80'(s1_found), 80'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1 check($sformatf("rst_r%0d", i), rd_all(), 80'd0);
    end
    check("rst_s0_all", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, 80'd0);
    check("rst_s1_all", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, 80'd0);

    // Write / search on s1, while s0 looks at the odd half of the same entry.
    wr(4'd5, 19'h12345, 8'h0A, 1'b0, 20'h00100, 3'd3, 1'b1, 1'b1,
       20'h00200, 3'd3, 1'b0, 1'b0);
    s1_vpn2 = 19'h12345; s1_odd_page = 1'b0; s1_asid = 8'h0A;
    s0_vpn2 = 19'h12345; s0_odd_page = 1'b1; s0_asid = 8'h0A;
    #1 check("ws_s1_even", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
             {55'd0, 1'b1, 4'd5, 20'h00100, 3'd3, 1'b1, 1'b1});
    check("ws_s0_odd", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
          {55'd0, 1'b1, 4'd5, 20'h00200, 3'd3, 1'b0, 1'b0});
    s1_odd_page = 1'b1;
    #1 check("ws_s1_odd", {s1_found, s1_index, s1_pfn, s1_v}, {54'd0, 1'b1, 4'd5, 20'h00200, 1'b0});
    s1_asid = 8'h0B;
    #1 check("ws_s1_asid_miss", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, 80'd0);
    r_index = 4'd5;
    #1 check("ws_read5", rd_all(), {2'b00, 19'h12345, 8'h0A, 1'b0, 20'h00100, 3'd3, 1'b1, 1'b1,
                                    20'h00200, 3'd3, 1'b0, 1'b0});

    // Global entries at 9 and 3: lowest index wins; rewriting 3 exposes 9.
    wr(4'd9, 19'h00ABC, 8'h11, 1'b1, 20'h00900, 3'd2, 1'b0, 1'b1,
       20'h00901, 3'd5, 1'b1, 1'b1);
    wr(4'd3, 19'h00ABC, 8'h22, 1'b1, 20'h00300, 3'd1, 1'b0, 1'b1,
       20'h00301, 3'd4, 1'b0, 1'b1);
    s0_vpn2 = 19'h00ABC; s0_odd_page = 1'b1; s0_asid = 8'hFF;
    #1 check("gp_prio3", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
             {55'd0, 1'b1, 4'd3, 20'h00301, 3'd4, 1'b0, 1'b1});
    r_index = 4'd9;
    #1 check("gp_read9", rd_all(), {2'b00, 19'h00ABC, 8'h11, 1'b1, 20'h00900, 3'd2, 1'b0, 1'b1,
                                    20'h00901, 3'd5, 1'b1, 1'b1});
    wr(4'd3, 19'h00ABD, 8'h22, 1'b1, 20'h00300, 3'd1, 1'b0, 1'b1,
       20'h00301, 3'd4, 1'b0, 1'b1);
    #1 check("gp_prio9", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
             {55'd0, 1'b1, 4'd9, 20'h00901, 3'd5, 1'b1, 1'b1});
    s1_vpn2 = 19'h00ABD; s1_odd_page = 1'b0; s1_asid = 8'h00;
    #1 check("gp_s1_abd", {s1_found, s1_index, s1_pfn}, {55'd0, 1'b1, 4'd3, 20'h00300});

    // Same-cycle write to entry 7: old (empty) before the edge, new after.
    @(negedge clk);
    s0_vpn2 = 19'h7FFFF; s0_odd_page = 1'b0; s0_asid = 8'hFF; r_index = 4'd7;
    we = 1'b1; w_index = 4'd7; w_vpn2 = 19'h7FFFF; w_asid = 8'hFF; w_g = 1'b0;
    w_pfn0 = 20'hFFFFF; w_c0 = 3'd7; w_d0 = 1'b1; w_v0 = 1'b1;
    w_pfn1 = 20'h00001; w_c1 = 3'd0; w_d1 = 1'b0; w_v1 = 1'b1;
    #1 check("sc_old_s0", {s0_found, s0_index, s0_pfn}, 80'd0);
    check("sc_old_r7", rd_all(), 80'd0);
    @(posedge clk);
    #1 we = 1'b0;
    check("sc_new_s0", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
          {55'd0, 1'b1, 4'd7, 20'hFFFFF, 3'd7, 1'b1, 1'b1});
    check("sc_new_r7", rd_all(), {2'b00, 19'h7FFFF, 8'hFF, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
                                  20'h00001, 3'd0, 1'b0, 1'b1});

    // Fill all entries, then assert reset between edges.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 19'h00100 + 19'(i), 8'(i), 1'b0, 20'(i + 1), 3'd1, 1'b0, 1'b1,
         20'h0, 3'd0, 1'b0, 1'b0);
    end
    s0_vpn2 = 19'h00100; s0_odd_page = 1'b0; s0_asid = 8'h00;
    s1_vpn2 = 19'h0010F; s1_odd_page = 1'b0; s1_asid = 8'h0F;
    r_index = 4'd2;
    #1 check("ar_pre_s0", {s0_found, s0_index, s0_pfn}, {55'd0, 1'b1, 4'd0, 20'd1});
    check("ar_pre_s1", {s1_found, s1_index, s1_pfn}, {55'd0, 1'b1, 4'd15, 20'd16});
    check("ar_pre_r2", 80'(r_vpn2), 80'h00102);
    #1 reset = 1'b1;
    we = 1'b1; w_index = 4'd4; w_vpn2 = 19'h00104; w_asid = 8'h04; w_pfn0 = 20'hABCDE; w_v0 = 1'b1;
    #1 check("ar_s0_found", 80'(s0_found), 80'd0);
    check("ar_s1_found", 80'(s1_found), 80'd0);
    check("ar_r2", rd_all(), 80'd0);
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1 check($sformatf("ar_r%0d", i), rd_all(), 80'd0);
    end
    we = 1'b0;
    @(negedge clk) reset = 1'b0;
    r_index = 4'd4; s0_vpn2 = 19'h00104; s0_asid = 8'h04;
    #1 check("ar_we_discard_r4", rd_all(), 80'd0);
    check("ar_we_discard_s0", {s0_found, s0_index, s0_pfn}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
